// File: rtl/pipeline_stage_chain_if.sv
// Decode-to-execute handoff bundle for pipeline_stage_chain.
//   in_valid : decode word present (master -> slave)
//   in_data  : decode control word (master -> slave)
//   in_ready : stage 0 accepts in_data this cycle (slave -> master)
interface pipeline_stage_chain_if #(
  parameter int unsigned DATA_W = 64
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready
  );
endinterface

// File: rtl/pipeline_stage_chain.sv
// Execute..writeback stage chain with per-stage stall/flush, a retire-driven
// PSW and retire/bubble performance counters.
//   clk, reset          : clock, asynchronous active-high reset
//   in_if (slave)       : in_valid/in_data in, in_ready out (= advance of stage 0)
//   stall, flush        : per-stage hold request and kill mask
//   stage_valid_o/data_o: registered per-stage valid bit and control word
//   retire_o            : last stage valid and leaving this cycle
//   psw_*               : PSW mask/update, branch-fail restore, current PSW
//   cnt_clear           : synchronous clear of both counters
//   retire_cnt_o        : retired words; bubble_cnt_o: last-stage empty cycles
module pipeline_stage_chain #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned STAGES = 3,
  parameter int unsigned CNT_W  = 32
) (
  input  logic                           clk,
  input  logic                           reset,
  pipeline_stage_chain_if.slave          in_if,
  input  logic [STAGES-1:0]              stall,
  input  logic [STAGES-1:0]              flush,
  output logic [STAGES-1:0]              stage_valid_o,
  output logic [STAGES-1:0][DATA_W-1:0]  stage_data_o,
  output logic                           retire_o,
  input  logic [15:0]                    psw_mask,
  input  logic [15:0]                    psw_in,
  input  logic                           psw_restore,
  input  logic [15:0]                    psw_restore_val,
  output logic [15:0]                    psw_o,
  input  logic                           cnt_clear,
  output logic [CNT_W-1:0]               retire_cnt_o,
  output logic [CNT_W-1:0]               bubble_cnt_o
);

  localparam int unsigned L = STAGES - 1;

  logic [STAGES-1:0]             valid_q, valid_d;
  logic [STAGES-1:0][DATA_W-1:0] data_q, data_d;
  logic [STAGES-1:0]             adv;
  logic [15:0]                   psw_q, psw_d;
  logic [CNT_W-1:0]              retire_cnt_q, retire_cnt_d;
  logic [CNT_W-1:0]              bubble_cnt_q, bubble_cnt_d;
  logic                          retire;

  // Advance ripples back from writeback; flush deliberately plays no part so a
  // word moving into a flushed stage is simply dropped.
  always_comb begin
    adv    = '0;
    adv[L] = !valid_q[L] || !stall[L];
    for (int i = int'(L) - 1; i >= 0; i--) begin
      adv[i] = !valid_q[i] || (!stall[i] && adv[i+1]);
    end
  end

  assign retire         = valid_q[L] && !stall[L];
  assign retire_o       = retire;
  assign in_if.in_ready = adv[0];

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (adv[0]) begin
      valid_d[0] = in_if.in_valid;
      data_d[0]  = in_if.in_valid ? in_if.in_data : '0;
    end
    for (int i = 1; i < int'(STAGES); i++) begin
      if (adv[i]) begin
        // A stalled upstream stage keeps its word, so this stage takes a bubble.
        if (valid_q[i-1] && !stall[i-1]) begin
          valid_d[i] = 1'b1;
          data_d[i]  = data_q[i-1];
        end else begin
          valid_d[i] = 1'b0;
          data_d[i]  = '0;
        end
      end
    end
    for (int i = 0; i < int'(STAGES); i++) begin
      if (flush[i]) begin
        valid_d[i] = 1'b0;
        data_d[i]  = '0;
      end
    end
  end

  always_comb begin
    psw_d = psw_q;
    if (psw_restore) begin
      psw_d = psw_restore_val;
    end else if (retire) begin
      psw_d = (psw_q & ~psw_mask) | (psw_in & psw_mask);
    end
  end

  always_comb begin
    retire_cnt_d = retire_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (cnt_clear) begin
      retire_cnt_d = '0;
      bubble_cnt_d = '0;
    end else begin
      if (retire)      retire_cnt_d = retire_cnt_q + CNT_W'(1);
      if (!valid_q[L]) bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q      <= '0;
      data_q       <= '0;
      psw_q        <= '0;
      retire_cnt_q <= '0;
      bubble_cnt_q <= '0;
    end else begin
      valid_q      <= valid_d;
      data_q       <= data_d;
      psw_q        <= psw_d;
      retire_cnt_q <= retire_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign stage_valid_o = valid_q;
  assign stage_data_o  = data_q;
  assign psw_o         = psw_q;
  assign retire_cnt_o  = retire_cnt_q;
  assign bubble_cnt_o  = bubble_cnt_q;

endmodule

// File: tb/tb_pipeline_stage_chain.sv
module tb_pipeline_stage_chain;
  localparam int unsigned DW = 16;
  localparam int unsigned NS = 3;
  localparam int unsigned CW = 4;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [NS-1:0]           stall, flush;
  logic [NS-1:0]           svalid;
  logic [NS-1:0][DW-1:0]   sdata;
  logic                    retire;
  logic [15:0]             psw_mask, psw_in, psw_restore_val, psw;
  logic                    psw_restore, cnt_clear;
  logic [CW-1:0]           rcnt, bcnt;

  int checks = 0;
  int errors = 0;

  pipeline_stage_chain_if #(.DATA_W(DW)) bus ();

  pipeline_stage_chain #(.DATA_W(DW), .STAGES(NS), .CNT_W(CW)) dut (
    .clk             (clk),
    .reset           (reset),
    .in_if           (bus.slave),
    .stall           (stall),
    .flush           (flush),
    .stage_valid_o   (svalid),
    .stage_data_o    (sdata),
    .retire_o        (retire),
    .psw_mask        (psw_mask),
    .psw_in          (psw_in),
    .psw_restore     (psw_restore),
    .psw_restore_val (psw_restore_val),
    .psw_o           (psw),
    .cnt_clear       (cnt_clear),
    .retire_cnt_o    (rcnt),
    .bubble_cnt_o    (bcnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d);
    bus.in_valid = v;
    bus.in_data  = d;
  endtask

  initial begin
    reset = 1'b1; stall = '0; flush = '0; cnt_clear = 1'b0;
    psw_mask = '0; psw_in = '0; psw_restore = 1'b0; psw_restore_val = '0;
    drive(1'b0, '0);
    #12;
    chk("rst_valid", 64'(svalid), 64'h0);
    chk("rst_data", 64'(sdata), 64'h0);
    chk("rst_psw", 64'(psw), 64'h0);
    chk("rst_ready", 64'(bus.in_ready), 64'h1);
    chk("rst_retire", 64'(retire), 64'h0);
    chk("rst_cnts", 64'({rcnt, bcnt}), 64'h0);
    reset = 1'b0;
    step();

    // Stream 1,2,3 on an empty pipe.
    cnt_clear = 1'b1; step(); cnt_clear = 1'b0;
    drive(1'b1, 16'd1); step();
    drive(1'b1, 16'd2); step();
    drive(1'b1, 16'd3); step();
    chk("s_w1_at_s2", 64'({svalid[2], sdata[2]}), 64'h1_0001);
    chk("s_retire_c3", 64'(retire), 64'h1);
    drive(1'b0, '0); step();
    chk("s_w2_at_s2", 64'(sdata[2]), 64'h2);
    chk("s_retire_c4", 64'(retire), 64'h1);
    step();
    chk("s_w3_at_s2", 64'(sdata[2]), 64'h3);
    chk("s_retire_c5", 64'(retire), 64'h1);
    step();
    chk("s_retire_cnt", 64'(rcnt), 64'h3);
    chk("s_bubble_cnt", 64'(bcnt), 64'h3);
    chk("s_empty", 64'(svalid), 64'h0);

    // Fill C,B,A then stall stage 1 for two cycles.
    drive(1'b1, 16'h000C); step();
    drive(1'b1, 16'h000B); step();
    drive(1'b1, 16'h000A); cnt_clear = 1'b1; step(); cnt_clear = 1'b0;
    chk("f_full", 64'({svalid, sdata[2], sdata[1], sdata[0]}), 64'h7_000C_000B_000A);
    stall = 3'b010; drive(1'b1, 16'h000D); #1;
    chk("st_ready0", 64'(bus.in_ready), 64'h0);
    chk("st_retireC", 64'(retire), 64'h1);
    step();
    chk("st1_stages", 64'({svalid, sdata[2], sdata[1], sdata[0]}), 64'h3_0000_000B_000A);
    chk("st1_cnts", 64'({rcnt, bcnt}), 64'h10);
    chk("st1_ready", 64'(bus.in_ready), 64'h0);
    chk("st1_retire", 64'(retire), 64'h0);
    step();
    chk("st2_bcnt", 64'(bcnt), 64'h1);
    chk("st2_s2", 64'({svalid[2], sdata[2]}), 64'h0);
    stall = '0; drive(1'b0, '0); step();
    chk("st3_stages", 64'({svalid, sdata[2], sdata[1], sdata[0]}), 64'h6_000B_000A_0000);
    chk("st3_bcnt", 64'(bcnt), 64'h2);

    // Refill with 11,22,33 then flush stages 0 and 1.
    drive(1'b1, 16'h0011); step();
    drive(1'b1, 16'h0022); step();
    drive(1'b1, 16'h0033); step();
    chk("fl_full", 64'({svalid, sdata[2], sdata[1], sdata[0]}), 64'h7_0011_0022_0033);
    chk("fl_rcnt0", 64'(rcnt), 64'h3);
    flush = 3'b011; drive(1'b0, '0); step(); flush = '0;
    chk("fl_after", 64'({svalid, sdata[2], sdata[1], sdata[0]}), 64'h4_0022_0000_0000);
    chk("fl_rcnt1", 64'(rcnt), 64'h4);
    step(); step();
    chk("fl_rcnt2", 64'(rcnt), 64'h5);
    chk("fl_empty", 64'(svalid), 64'h0);

    // PSW masked update, hold, restore priority, partial mask.
    drive(1'b1, 16'h0044); step();
    drive(1'b0, '0); step(); step();
    chk("p_retire", 64'(retire), 64'h1);
    psw_mask = 16'h000F; psw_in = 16'hFFFF; #1;
    chk("p_prev", 64'(psw), 64'h0);
    step();
    chk("p_masked", 64'(psw), 64'h000F);
    step();
    chk("p_hold", 64'(psw), 64'h000F);
    psw_mask = '0;
    drive(1'b1, 16'h0055); step();
    drive(1'b1, 16'h0066); step();
    drive(1'b0, '0); step();
    psw_mask = 16'h000F; psw_in = 16'hFFFF; psw_restore = 1'b1; psw_restore_val = 16'h1234;
    step();
    chk("p_restore", 64'(psw), 64'h1234);
    psw_restore = 1'b0; psw_mask = 16'h00F0; psw_in = 16'h0A50;
    step();
    chk("p_partial", 64'(psw), 64'h1254);
    psw_mask = '0;

    // Counter wrap and clear-vs-increment.
    flush = 3'b111; cnt_clear = 1'b1; step(); flush = '0; cnt_clear = 1'b0;
    chk("w_cleared", 64'({svalid, rcnt, bcnt}), 64'h0);
    drive(1'b1, 16'h0099);
    for (int k = 0; k < 18; k++) step();
    chk("w_r15", 64'(rcnt), 64'hF);
    chk("w_b3", 64'(bcnt), 64'h3);
    step();
    chk("w_wrap", 64'(rcnt), 64'h0);
    cnt_clear = 1'b1; step(); cnt_clear = 1'b0;
    chk("w_clr_over_inc", 64'({rcnt, bcnt}), 64'h0);
    step();
    chk("w_after_clr", 64'({rcnt, bcnt}), 64'h10);

    // Asynchronous reset with a full pipe, between edges.
    #1 reset = 1'b1;
    #1;
    chk("ar_valid", 64'(svalid), 64'h0);
    chk("ar_data", 64'(sdata), 64'h0);
    chk("ar_psw", 64'(psw), 64'h0);
    chk("ar_ready_retire", 64'({bus.in_ready, retire}), 64'h2);
    chk("ar_cnts", 64'({rcnt, bcnt}), 64'h0);
    reset = 1'b0;
    drive(1'b1, 16'h0077); step();
    chk("ar_first", 64'({svalid, sdata[2], sdata[1], sdata[0]}), 64'h1_0000_0000_0077);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/pipeline_stage_chain.md
PIPELINE_STAGE_CHAIN -- requirements
Module: pipeline_stage_chain

Interface
REQ-001 SHALL have parameter DATA_W, default 64: control-word width per stage.
REQ-002 SHALL have parameter STAGES, default 3, legal range 2..8: pipeline depth; stage 0 is first (execute), stage STAGES-1 is last (writeback).
REQ-003 SHALL have parameter CNT_W, default 32: performance counter width.
REQ-004 clk  in  1  sole clock; all state updates on the rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 in_valid  in  1  decode word present.
REQ-007 in_data  in  DATA_W  decode control word.
REQ-008 in_ready  out  1  stage 0 accepts in_data this cycle.
REQ-009 stall  in  STAGES  per-stage hold request; bit i holds stage i.
REQ-010 flush  in  STAGES  per-stage kill mask; bit i makes stage i a bubble.
REQ-011 stage_valid_o  out  STAGES  valid bit per stage.
REQ-012 stage_data_o  out  STAGES x DATA_W  control word per stage.
REQ-013 retire_o  out  1  last stage valid and leaving this cycle.
REQ-014 psw_mask, psw_in  in  16 each  PSW per-bit update mask and new flags.
REQ-015 psw_restore, psw_restore_val  in  1, 16  branch-fail restore request and value.
REQ-016 psw_o  out  16  current PSW.
REQ-017 cnt_clear  in  1  synchronous clear of both counters.
REQ-018 retire_cnt_o, bubble_cnt_o  out  CNT_W each  retired words; last-stage empty cycles.

Function
REQ-019 Last stage SHALL advance when !valid[L] or !stall[L]; stage i<L SHALL advance when !valid[i] or (!stall[i] and advance[i+1]).
REQ-020 in_ready SHALL equal advance[0], combinationally; input accepted when in_valid and in_ready.
REQ-021 Advancing stage i>0 SHALL load stage i-1 contents if stage i-1 valid and not held (!stall[i-1]), else load a bubble.
REQ-022 Advancing stage 0 SHALL load in_data with valid=1 if in_valid, else a bubble.
REQ-023 A bubble SHALL be valid=0, data=0.
REQ-024 A non-advancing stage SHALL hold valid and data unchanged.
REQ-025 flush[i] SHALL force stage i to a bubble at the next edge, overriding hold and load; advance/in_ready computation SHALL ignore flush, so a word moving into a flushed stage is discarded.
REQ-026 No valid word SHALL be duplicated or lost except by flush; a word passes stage 0..L in exactly STAGES cycles when no stall/flush occurs.
REQ-027 retire_o SHALL be valid[L] and !stall[L], combinationally.
REQ-028 PSW: psw_restore SHALL load psw_restore_val; else on retire_o, PSW <= (PSW & ~psw_mask) | (psw_in & psw_mask); else hold.
REQ-029 retire_cnt SHALL increment on retire_o; bubble_cnt SHALL increment each cycle valid[L]=0; both wrap modulo 2^CNT_W.
REQ-030 cnt_clear SHALL zero both counters, overriding increment in the same cycle.
REQ-031 All outputs except in_ready and retire_o SHALL be registered.

Reset
REQ-032 reset SHALL asynchronously set all valid bits 0, all data 0, PSW 0x0000, both counters 0; in_ready=1, retire_o=0 while asserted.
REQ-033 reset asserted mid-operation SHALL discard all in-flight words; first word after deassertion SHALL be treated as on an empty pipe.

Verification
REQ-034 STAGES=3, stream in_data 1,2,3 with no stall -> word 1 at stage 2 on cycle 3, retire_o on cycles 3,4,5, retire_cnt=3.
REQ-035 Pipe full (A,B,C), stall[1]=1 for 2 cycles -> stages 0,1 hold, in_ready=0, stage 2 retires C then shows bubble, bubble_cnt increments by 1 per bubble cycle.
REQ-036 Pipe full, flush=3'b011 for 1 cycle -> stages 0,1 valid=0 data=0 next cycle, stage 2 retains its prior stage-1 word? no: stage 2 loads old stage 1 word (not flushed), retire_cnt unchanged for killed words.
REQ-037 PSW=0x0000, psw_mask=0x000F, psw_in=0xFFFF with retire_o=1 -> psw_o=0x000F; same cycle psw_restore=1, val=0x1234 -> psw_o=0x1234.
REQ-038 Counters preset near wrap (CNT_W=4, retire_cnt=15), one retire -> 0; cnt_clear with retire -> 0.
REQ-039 reset pulse between edges with full pipe -> outputs clear immediately, PSW 0, in_ready=1.
